// File: rtl/pd_rx_multi_sop.sv
// USB-PD protocol-layer receiver for up to N_SOP SOP* types.
// Stages PHY bytes, acknowledges with GoodCRC, tracks MessageIDs, buffers messages.
module pd_rx_multi_sop #(
  parameter int N_SOP        = 3,
  parameter int SOPW         = 3,
  parameter int BUF_DEPTH    = 32,
  parameter int CNTW         = 6,
  parameter int GCRC_TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            hard_reset,
  input  logic [7:0]      MESSAGE_HEADER_INFO,
  input  logic [7:0]      RECEIVE_DETECT,
  input  logic            phy_rx_sop,
  input  logic [SOPW-1:0] phy_rx_sop_type,
  input  logic            phy_rx_valid,
  input  logic [7:0]      phy_rx_data,
  input  logic            phy_rx_eom,
  input  logic            phy_rx_crc_err,
  input  logic            phy_rx_hard_reset,
  input  logic            GoodCRC_Transmission_Complete,
  input  logic            rx_buf_rd,
  input  logic            rx_alert_clr,
  output logic            tx_goodcrc_req,
  output logic [7:0]      TX_BUF_HEADER_BYTE_0,
  output logic [7:0]      TX_BUF_HEADER_BYTE_1,
  output logic            rx_msg_ready,
  output logic [SOPW-1:0] rx_sop_out,
  output logic [CNTW-1:0] rx_byte_count,
  output logic [7:0]      rx_buf_data,
  output logic            phy_rx_goodcrc,
  output logic            RECEIVE_DETECT_retro
);

  localparam int TW = $clog2(GCRC_TIMEOUT + 1);
  localparam int AW = $clog2(BUF_DEPTH);

  typedef enum logic [2:0] {
    IDLE, RECV, CHECK, GCRC, STORE, DROP
  } state_t;

  state_t          state;
  logic [7:0]      stage [BUF_DEPTH];
  logic [7:0]      rbuf  [BUF_DEPTH];
  logic [CNTW-1:0] wp;
  logic [CNTW-1:0] rp;
  logic [SOPW-1:0] cur_sop;
  logic [TW-1:0]   tmr;
  logic [N_SOP-1:0] id_valid;
  logic [2:0]      id_val [N_SOP];

  logic [4:0] h_type;
  logic [2:0] h_ndo;
  logic [2:0] h_id;
  logic       is_gcrc;
  logic       is_srst;
  logic       sop_ok;
  logic       id_hit;
  logic       dup;
  logic       hr_det;
  logic       is_sop;
  logic       unused_ok;

  assign h_type  = stage[0][4:0];
  assign h_ndo   = stage[1][6:4];
  assign h_id    = stage[1][3:1];
  assign is_gcrc = (h_ndo == 3'd0) && (h_type == 5'h01);
  assign is_srst = (h_ndo == 3'd0) && (h_type == 5'h0D);
  assign dup     = id_hit && !is_srst;
  assign hr_det  = phy_rx_hard_reset && RECEIVE_DETECT[5];
  assign is_sop  = (cur_sop == '0);

  assign rx_buf_data = (rp < CNTW'(BUF_DEPTH)) ? rbuf[rp[AW-1:0]] : 8'h00;

  assign unused_ok = ^{MESSAGE_HEADER_INFO, RECEIVE_DETECT};

  // Incoming SOP* type is handled and enabled by RECEIVE_DETECT
  always_comb begin
    sop_ok = 1'b0;
    for (int i = 0; i < N_SOP; i++)
      if (phy_rx_sop_type == SOPW'(i) && RECEIVE_DETECT[i])
        sop_ok = 1'b1;
  end

  // Stored MessageID of the current SOP type matches the staged header
  always_comb begin
    id_hit = 1'b0;
    for (int i = 0; i < N_SOP; i++)
      if (cur_sop == SOPW'(i))
        id_hit = id_valid[i] && (id_val[i] == h_id);
  end

  // Receive FSM, MessageID table, buffer and all registered outputs
  always_ff @(posedge clk or posedge hard_reset) begin
    if (hard_reset) begin
      state                <= IDLE;
      wp                   <= '0;
      rp                   <= '0;
      cur_sop              <= '0;
      tmr                  <= '0;
      id_valid             <= '0;
      tx_goodcrc_req       <= 1'b0;
      TX_BUF_HEADER_BYTE_0 <= 8'h00;
      TX_BUF_HEADER_BYTE_1 <= 8'h00;
      rx_msg_ready         <= 1'b0;
      rx_sop_out           <= '0;
      rx_byte_count        <= '0;
      phy_rx_goodcrc       <= 1'b0;
      RECEIVE_DETECT_retro <= 1'b0;
      for (int i = 0; i < N_SOP; i++)
        id_val[i] <= 3'd0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        stage[i] <= 8'h00;
        rbuf[i]  <= 8'h00;
      end
    end else if (hr_det) begin
      state                <= IDLE;
      id_valid             <= '0;
      tx_goodcrc_req       <= 1'b0;
      rx_msg_ready         <= 1'b0;
      rx_byte_count        <= '0;
      rp                   <= '0;
      phy_rx_goodcrc       <= 1'b0;
      RECEIVE_DETECT_retro <= 1'b1;
    end else begin
      phy_rx_goodcrc       <= 1'b0;
      RECEIVE_DETECT_retro <= 1'b0;

      if (rx_buf_rd && rx_byte_count != '0) begin
        rp            <= rp + 1'b1;
        rx_byte_count <= rx_byte_count - 1'b1;
      end
      if (rx_alert_clr) begin
        rx_msg_ready  <= 1'b0;
        rx_byte_count <= '0;
        rp            <= '0;
      end

      case (state)
        IDLE: begin
          if (phy_rx_sop) begin
            cur_sop <= phy_rx_sop_type;
            wp      <= '0;
            state   <= (sop_ok && !rx_msg_ready) ? RECV : DROP;
          end
        end
        RECV: begin
          if (phy_rx_sop) begin
            cur_sop <= phy_rx_sop_type;
            wp      <= '0;
            state   <= sop_ok ? RECV : DROP;
          end else if (phy_rx_crc_err) begin
            state <= IDLE;
          end else if (phy_rx_eom) begin
            state <= (wp < CNTW'(2)) ? IDLE : CHECK;
          end else if (phy_rx_valid) begin
            if (wp == CNTW'(BUF_DEPTH)) begin
              state <= DROP;
            end else begin
              stage[wp[AW-1:0]] <= phy_rx_data;
              wp                <= wp + 1'b1;
            end
          end
        end
        CHECK: begin
          if (is_gcrc) begin
            phy_rx_goodcrc <= 1'b1;
            state          <= IDLE;
          end else begin
            TX_BUF_HEADER_BYTE_0 <= {MESSAGE_HEADER_INFO[2:1],
                                     is_sop & MESSAGE_HEADER_INFO[3],
                                     5'b00001};
            TX_BUF_HEADER_BYTE_1 <= {4'b0000, h_id,
                                     is_sop ? MESSAGE_HEADER_INFO[0]
                                            : MESSAGE_HEADER_INFO[4]};
            tx_goodcrc_req <= 1'b1;
            tmr            <= '0;
            state          <= GCRC;
          end
        end
        GCRC: begin
          if (GoodCRC_Transmission_Complete) begin
            tx_goodcrc_req <= 1'b0;
            if (dup) begin
              state <= IDLE;
            end else begin
              // Soft_Reset clears then rewrites the entry: net effect is valid
              for (int i = 0; i < N_SOP; i++)
                if (cur_sop == SOPW'(i)) begin
                  id_valid[i] <= 1'b1;
                  id_val[i]   <= h_id;
                end
              state <= STORE;
            end
          end else if (tmr == TW'(GCRC_TIMEOUT - 1)) begin
            tx_goodcrc_req <= 1'b0;
            state          <= IDLE;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        STORE: begin
          rbuf          <= stage;
          rx_byte_count <= wp;
          rp            <= '0;
          rx_sop_out    <= cur_sop;
          rx_msg_ready  <= 1'b1;
          state         <= IDLE;
        end
        DROP: begin
          if (phy_rx_eom || phy_rx_crc_err)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pd_rx_multi_sop.sv
// Directed bench for pd_rx_multi_sop.
// Each task drives one scenario and checks against hand-derived values.
module tb_pd_rx_multi_sop;

  logic       clk = 1'b0;
  logic       hard_reset;
  logic [7:0] MESSAGE_HEADER_INFO;
  logic [7:0] RECEIVE_DETECT;
  logic       phy_rx_sop;
  logic [2:0] phy_rx_sop_type;
  logic       phy_rx_valid;
  logic [7:0] phy_rx_data;
  logic       phy_rx_eom;
  logic       phy_rx_crc_err;
  logic       phy_rx_hard_reset;
  logic       GoodCRC_Transmission_Complete;
  logic       rx_buf_rd;
  logic       rx_alert_clr;
  logic       tx_goodcrc_req;
  logic [7:0] TX_BUF_HEADER_BYTE_0;
  logic [7:0] TX_BUF_HEADER_BYTE_1;
  logic       rx_msg_ready;
  logic [2:0] rx_sop_out;
  logic [5:0] rx_byte_count;
  logic [7:0] rx_buf_data;
  logic       phy_rx_goodcrc;
  logic       RECEIVE_DETECT_retro;

  int n_cmp = 0;
  int n_bad = 0;
  int req_cyc = 0;
  int gcrc_pul = 0;
  int retro_pul = 0;

  always #5 clk = ~clk;

  pd_rx_multi_sop dut (
    .clk                           (clk),
    .hard_reset                    (hard_reset),
    .MESSAGE_HEADER_INFO           (MESSAGE_HEADER_INFO),
    .RECEIVE_DETECT                (RECEIVE_DETECT),
    .phy_rx_sop                    (phy_rx_sop),
    .phy_rx_sop_type               (phy_rx_sop_type),
    .phy_rx_valid                  (phy_rx_valid),
    .phy_rx_data                   (phy_rx_data),
    .phy_rx_eom                    (phy_rx_eom),
    .phy_rx_crc_err                (phy_rx_crc_err),
    .phy_rx_hard_reset             (phy_rx_hard_reset),
    .GoodCRC_Transmission_Complete (GoodCRC_Transmission_Complete),
    .rx_buf_rd                     (rx_buf_rd),
    .rx_alert_clr                  (rx_alert_clr),
    .tx_goodcrc_req                (tx_goodcrc_req),
    .TX_BUF_HEADER_BYTE_0          (TX_BUF_HEADER_BYTE_0),
    .TX_BUF_HEADER_BYTE_1          (TX_BUF_HEADER_BYTE_1),
    .rx_msg_ready                  (rx_msg_ready),
    .rx_sop_out                    (rx_sop_out),
    .rx_byte_count                 (rx_byte_count),
    .rx_buf_data                   (rx_buf_data),
    .phy_rx_goodcrc                (phy_rx_goodcrc),
    .RECEIVE_DETECT_retro          (RECEIVE_DETECT_retro)
  );

  // Event counters for strobes and request cycles
  always @(posedge clk) begin
    if (tx_goodcrc_req) req_cyc <= req_cyc + 1;
    if (phy_rx_goodcrc) gcrc_pul <= gcrc_pul + 1;
    if (RECEIVE_DETECT_retro) retro_pul <= retro_pul + 1;
  end

  task automatic sop(input logic [2:0] t);
    @(negedge clk); phy_rx_sop = 1'b1; phy_rx_sop_type = t;
    @(negedge clk); phy_rx_sop = 1'b0;
  endtask

  task automatic byte_in(input logic [7:0] b);
    @(negedge clk); phy_rx_valid = 1'b1; phy_rx_data = b;
    @(negedge clk); phy_rx_valid = 1'b0;
  endtask

  task automatic eom();
    @(negedge clk); phy_rx_eom = 1'b1;
    @(negedge clk); phy_rx_eom = 1'b0;
  endtask

  task automatic crc_bad();
    @(negedge clk); phy_rx_crc_err = 1'b1;
    @(negedge clk); phy_rx_crc_err = 1'b0;
  endtask

  task automatic complete();
    @(negedge clk); GoodCRC_Transmission_Complete = 1'b1;
    @(negedge clk); GoodCRC_Transmission_Complete = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic rd();
    @(negedge clk); rx_buf_rd = 1'b1;
    @(negedge clk); rx_buf_rd = 1'b0;
  endtask

  task automatic clr();
    @(negedge clk); rx_alert_clr = 1'b1;
    @(negedge clk); rx_alert_clr = 1'b0;
  endtask

  task automatic send2(input logic [2:0] t, input logic [7:0] b0,
                       input logic [7:0] b1);
    sop(t); byte_in(b0); byte_in(b1); eom();
  endtask

  task automatic wait_req();
    for (int k = 0; k < 8; k++) begin
      if (tx_goodcrc_req) break;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    hard_reset = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (tx_goodcrc_req !== 1'b0) begin n_bad++;
      $display("FAIL rst_req: got %b want 0", tx_goodcrc_req); end
    n_cmp++; if (rx_msg_ready !== 1'b0) begin n_bad++;
      $display("FAIL rst_ready: got %b want 0", rx_msg_ready); end
    n_cmp++; if (rx_byte_count !== 6'd0) begin n_bad++;
      $display("FAIL rst_count: got %0d want 0", rx_byte_count); end
    n_cmp++; if ({TX_BUF_HEADER_BYTE_1, TX_BUF_HEADER_BYTE_0, rx_buf_data} !== 24'h0) begin n_bad++;
      $display("FAIL rst_bytes: got %h want 000000",
               {TX_BUF_HEADER_BYTE_1, TX_BUF_HEADER_BYTE_0, rx_buf_data}); end
    hard_reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    send2(3'd0, 8'h41, 8'h12);
    wait_req();
    n_cmp++; if (tx_goodcrc_req !== 1'b1) begin n_bad++;
      $display("FAIL basic_req: got %b want 1", tx_goodcrc_req); end
    n_cmp++; if (TX_BUF_HEADER_BYTE_0 !== 8'h01) begin n_bad++;
      $display("FAIL basic_hdr0: got %h want 01", TX_BUF_HEADER_BYTE_0); end
    n_cmp++; if (TX_BUF_HEADER_BYTE_1 !== 8'h02) begin n_bad++;
      $display("FAIL basic_hdr1: got %h want 02", TX_BUF_HEADER_BYTE_1); end
    complete();
    n_cmp++; if (rx_msg_ready !== 1'b1) begin n_bad++;
      $display("FAIL basic_ready: got %b want 1", rx_msg_ready); end
    n_cmp++; if (rx_byte_count !== 6'd2) begin n_bad++;
      $display("FAIL basic_count: got %0d want 2", rx_byte_count); end
    n_cmp++; if (rx_buf_data !== 8'h41) begin n_bad++;
      $display("FAIL basic_b0: got %h want 41", rx_buf_data); end
    n_cmp++; if (rx_sop_out !== 3'd0) begin n_bad++;
      $display("FAIL basic_sop: got %0d want 0", rx_sop_out); end
    rd();
    n_cmp++; if (rx_buf_data !== 8'h12) begin n_bad++;
      $display("FAIL basic_b1: got %h want 12", rx_buf_data); end
    n_cmp++; if (rx_byte_count !== 6'd1) begin n_bad++;
      $display("FAIL basic_cnt1: got %0d want 1", rx_byte_count); end
    rd(); rd();
    n_cmp++; if (rx_byte_count !== 6'd0) begin n_bad++;
      $display("FAIL basic_rd_empty: got %0d want 0", rx_byte_count); end
    clr();
    n_cmp++; if (rx_msg_ready !== 1'b0) begin n_bad++;
      $display("FAIL basic_clr: got %b want 0", rx_msg_ready); end
  endtask

  task automatic test_dup();
    send2(3'd0, 8'h41, 8'h12);
    wait_req();
    n_cmp++; if (tx_goodcrc_req !== 1'b1 || TX_BUF_HEADER_BYTE_1 !== 8'h02) begin n_bad++;
      $display("FAIL dup_ack: got req %b hdr1 %h want 1 02",
               tx_goodcrc_req, TX_BUF_HEADER_BYTE_1); end
    complete();
    n_cmp++; if (rx_msg_ready !== 1'b0) begin n_bad++;
      $display("FAIL dup_ready: got %b want 0", rx_msg_ready); end
    send2(3'd0, 8'h0D, 8'h02);
    wait_req();
    n_cmp++; if (tx_goodcrc_req !== 1'b1 || TX_BUF_HEADER_BYTE_1 !== 8'h02) begin n_bad++;
      $display("FAIL srst_ack: got req %b hdr1 %h want 1 02",
               tx_goodcrc_req, TX_BUF_HEADER_BYTE_1); end
    complete();
    n_cmp++; if (rx_msg_ready !== 1'b1 || rx_buf_data !== 8'h0D) begin n_bad++;
      $display("FAIL srst_store: got ready %b data %h want 1 0d",
               rx_msg_ready, rx_buf_data); end
    clr();
  endtask

  task automatic test_sop_filter();
    int r0;
    r0 = req_cyc;
    send2(3'd1, 8'h41, 8'h12);
    repeat (4) @(negedge clk);
    n_cmp++; if (req_cyc - r0 !== 0 || rx_msg_ready !== 1'b0) begin n_bad++;
      $display("FAIL filt_drop: got req %0d ready %b want 0 0",
               req_cyc - r0, rx_msg_ready); end
    RECEIVE_DETECT = 8'h03;
    MESSAGE_HEADER_INFO = 8'h10;
    send2(3'd1, 8'h41, 8'h12);
    wait_req();
    n_cmp++; if (TX_BUF_HEADER_BYTE_0 !== 8'h01) begin n_bad++;
      $display("FAIL cable_hdr0: got %h want 01", TX_BUF_HEADER_BYTE_0); end
    n_cmp++; if (TX_BUF_HEADER_BYTE_1 !== 8'h03) begin n_bad++;
      $display("FAIL cable_hdr1: got %h want 03", TX_BUF_HEADER_BYTE_1); end
    complete();
    n_cmp++; if (rx_msg_ready !== 1'b1 || rx_sop_out !== 3'd1) begin n_bad++;
      $display("FAIL cable_store: got ready %b sop %0d want 1 1",
               rx_msg_ready, rx_sop_out); end
    clr();
    MESSAGE_HEADER_INFO = 8'h0F;
    send2(3'd0, 8'h41, 8'h16);
    wait_req();
    n_cmp++; if (TX_BUF_HEADER_BYTE_0 !== 8'hE1) begin n_bad++;
      $display("FAIL role_hdr0: got %h want e1", TX_BUF_HEADER_BYTE_0); end
    n_cmp++; if (TX_BUF_HEADER_BYTE_1 !== 8'h07) begin n_bad++;
      $display("FAIL role_hdr1: got %h want 07", TX_BUF_HEADER_BYTE_1); end
    complete();
    n_cmp++; if (rx_msg_ready !== 1'b1) begin n_bad++;
      $display("FAIL role_store: got %b want 1", rx_msg_ready); end
    clr();
    MESSAGE_HEADER_INFO = 8'h00;
    RECEIVE_DETECT = 8'h01;
  endtask

  task automatic test_overflow();
    int r0;
    r0 = req_cyc;
    sop(3'd0);
    for (int i = 0; i < 33; i++) byte_in(8'h50 + 8'(i));
    eom();
    repeat (4) @(negedge clk);
    n_cmp++; if (req_cyc - r0 !== 0 || rx_byte_count !== 6'd0) begin n_bad++;
      $display("FAIL ovf: got req %0d count %0d want 0 0",
               req_cyc - r0, rx_byte_count); end
    r0 = req_cyc;
    sop(3'd0);
    for (int i = 0; i < 4; i++) byte_in(8'h41 + 8'(i));
    crc_bad();
    repeat (4) @(negedge clk);
    n_cmp++; if (req_cyc - r0 !== 0 || rx_msg_ready !== 1'b0) begin n_bad++;
      $display("FAIL crcerr: got req %0d ready %b want 0 0",
               req_cyc - r0, rx_msg_ready); end
    sop(3'd0);
    for (int i = 0; i < 32; i++) byte_in(8'h50 + 8'(i));
    eom();
    wait_req();
    n_cmp++; if (tx_goodcrc_req !== 1'b1 || TX_BUF_HEADER_BYTE_1 !== 8'h00) begin n_bad++;
      $display("FAIL full_ack: got req %b hdr1 %h want 1 00",
               tx_goodcrc_req, TX_BUF_HEADER_BYTE_1); end
    complete();
    n_cmp++; if (rx_byte_count !== 6'd32) begin n_bad++;
      $display("FAIL full_count: got %0d want 32", rx_byte_count); end
    for (int i = 0; i < 32; i++) begin
      n_cmp++; if (rx_buf_data !== 8'h50 + 8'(i)) begin n_bad++;
        $display("FAIL full_byte%0d: got %h want %h", i, rx_buf_data,
                 8'h50 + 8'(i)); end
      rd();
    end
    rd();
    n_cmp++; if (rx_byte_count !== 6'd0) begin n_bad++;
      $display("FAIL full_empty: got %0d want 0", rx_byte_count); end
    clr();
  endtask

  task automatic test_goodcrc_rx();
    int g0, r0;
    g0 = gcrc_pul;
    r0 = req_cyc;
    send2(3'd0, 8'h01, 8'h00);
    repeat (4) @(negedge clk);
    n_cmp++; if (gcrc_pul - g0 !== 1) begin n_bad++;
      $display("FAIL gcrc_pulse: got %0d want 1", gcrc_pul - g0); end
    n_cmp++; if (req_cyc - r0 !== 0 || rx_msg_ready !== 1'b0) begin n_bad++;
      $display("FAIL gcrc_nostore: got req %0d ready %b want 0 0",
               req_cyc - r0, rx_msg_ready); end
  endtask

  task automatic test_hard_reset();
    int t0;
    RECEIVE_DETECT = 8'h21;
    send2(3'd0, 8'h41, 8'h10);
    wait_req();
    complete();
    n_cmp++; if (rx_msg_ready !== 1'b0) begin n_bad++;
      $display("FAIL hr_predup: got %b want 0", rx_msg_ready); end
    send2(3'd0, 8'h41, 8'h10);
    wait_req();
    t0 = retro_pul;
    @(negedge clk); phy_rx_hard_reset = 1'b1;
    @(negedge clk); phy_rx_hard_reset = 1'b0;
    @(negedge clk);
    n_cmp++; if (retro_pul - t0 !== 1) begin n_bad++;
      $display("FAIL hr_retro: got %0d want 1", retro_pul - t0); end
    n_cmp++; if (tx_goodcrc_req !== 1'b0) begin n_bad++;
      $display("FAIL hr_req: got %b want 0", tx_goodcrc_req); end
    send2(3'd0, 8'h41, 8'h10);
    wait_req();
    complete();
    n_cmp++; if (rx_msg_ready !== 1'b1) begin n_bad++;
      $display("FAIL hr_accept: got %b want 1", rx_msg_ready); end
    clr();
  endtask

  task automatic test_timeout();
    send2(3'd0, 8'h41, 8'h14);
    wait_req();
    n_cmp++; if (tx_goodcrc_req !== 1'b1 || TX_BUF_HEADER_BYTE_1 !== 8'h04) begin n_bad++;
      $display("FAIL to_ack: got req %b hdr1 %h want 1 04",
               tx_goodcrc_req, TX_BUF_HEADER_BYTE_1); end
    repeat (256) @(negedge clk);
    n_cmp++; if (tx_goodcrc_req !== 1'b0) begin n_bad++;
      $display("FAIL to_req: got %b want 0", tx_goodcrc_req); end
    complete();
    n_cmp++; if (rx_msg_ready !== 1'b0) begin n_bad++;
      $display("FAIL to_nostore: got %b want 0", rx_msg_ready); end
    send2(3'd0, 8'h41, 8'h14);
    wait_req();
    complete();
    n_cmp++; if (rx_msg_ready !== 1'b1) begin n_bad++;
      $display("FAIL to_retry: got %b want 1", rx_msg_ready); end
    clr();
  endtask

  initial begin
    MESSAGE_HEADER_INFO = 8'h00;
    RECEIVE_DETECT = 8'h01;
    phy_rx_sop = 1'b0;
    phy_rx_sop_type = 3'd0;
    phy_rx_valid = 1'b0;
    phy_rx_data = 8'h00;
    phy_rx_eom = 1'b0;
    phy_rx_crc_err = 1'b0;
    phy_rx_hard_reset = 1'b0;
    GoodCRC_Transmission_Complete = 1'b0;
    rx_buf_rd = 1'b0;
    rx_alert_clr = 1'b0;
    test_reset();
    test_basic();
    test_dup();
    test_sop_filter();
    test_overflow();
    test_goodcrc_rx();
    test_hard_reset();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
